// File: rtl/cksum_seq_ctrl_if.sv
// rtl/cksum_seq_ctrl_if.sv - request/grant data-memory bus used by the checksum sequencer
//
// Signals:
//   mem_req     requester -> arbiter   memory request
//   mem_we      requester -> arbiter   1 = write, 0 = read
//   mem_addr    requester -> arbiter   word-aligned byte address
//   mem_wdata   requester -> arbiter   write data
//   mem_gnt     arbiter   -> requester request accepted this cycle
//   mem_rvalid  arbiter   -> requester read data valid
//   mem_rdata   arbiter   -> requester read data
// Modports: master (sequencer side), slave (memory/arbiter side).

interface cksum_seq_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/cksum_seq_ctrl.sv
// rtl/cksum_seq_ctrl.sv - logical-fold checksum sequencer on the shared data-memory port
//
// Reads word_count words from src_addr, folds each word w into the accumulator
// (acc ^= w ^ ((w >> 3) & (w << 5))), then writes the checksum to dst_addr and
// the reverted value (checksum ^ T == init_val) to dst_addr+4.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start                  one-cycle start pulse, accepted only when idle
//   init_val, src_addr,
//   dst_addr, word_count   job parameters, sampled with start
//   busy                   job in progress
//   done, error            completion pulse; error marks an aborted job
//   checksum               last successful checksum
//   mem                    memory bus (cksum_seq_ctrl_if.master)
//
// Optional feature: define CKSUM_TIMEOUT_EN to abort a job with error when a
// grant or read response has not arrived within TIMEOUT cycles.

module cksum_seq_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       init_val,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum,
    cksum_seq_ctrl_if.master  mem
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_SUM,
        S_WR_REV,
        S_FIN
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] dst_q;
    logic [CNT_W-1:0]  remain;
    logic [31:0]       acc;
    logic [31:0]       tacc;
    logic              err_q;
    logic [31:0]       checksum_q;
    logic              misaligned;
    logic              timed_out;

    function automatic logic [31:0] fold_term(input logic [31:0] w);
        return w ^ ((w >> 3) & (w << 5));
    endfunction

    assign misaligned = (cur_addr[1:0] != 2'b00) || (dst_q[1:0] != 2'b00);

`ifdef CKSUM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              in_wait;
    logic              leaving_wait;

    assign in_wait = (state == S_RD_REQ) || (state == S_RD_WAIT) ||
                     (state == S_WR_SUM) || (state == S_WR_REV);

    // Progress events are computed from inputs only, so the abort decision
    // does not loop back through state_next.
    assign leaving_wait = ((state == S_RD_REQ)  && mem.mem_gnt)    ||
                          ((state == S_RD_WAIT) && mem.mem_rvalid) ||
                          ((state == S_WR_SUM)  && mem.mem_gnt)    ||
                          ((state == S_WR_REV)  && mem.mem_gnt);

    assign timed_out = in_wait && !leaving_wait &&
                       (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if (in_wait) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end
`else
    logic unused_timeout;

    assign timed_out      = 1'b0;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (misaligned) begin
                    state_next = S_FIN;
                end else if (remain == '0) begin
                    state_next = S_WR_SUM;
                end else begin
                    state_next = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = cur_addr;
                if (mem.mem_gnt) begin
                    state_next = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (mem.mem_rvalid) begin
                    state_next = (remain == CNT_W'(1)) ? S_WR_SUM : S_RD_REQ;
                end
            end
            S_WR_SUM: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = dst_q;
                mem.mem_wdata = acc;
                if (mem.mem_gnt) begin
                    state_next = S_WR_REV;
                end
            end
            S_WR_REV: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = dst_q + ADDR_W'(4);
                mem.mem_wdata = acc ^ tacc;
                if (mem.mem_gnt) begin
                    state_next = S_FIN;
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (timed_out) begin
            state_next = S_FIN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr   <= '0;
            dst_q      <= '0;
            remain     <= '0;
            acc        <= '0;
            tacc       <= '0;
            err_q      <= 1'b0;
            checksum_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_addr <= src_addr;
                        dst_q    <= dst_addr;
                        remain   <= word_count;
                        acc      <= init_val;
                        tacc     <= '0;
                        err_q    <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (misaligned) begin
                        err_q <= 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    if (mem.mem_rvalid) begin
                        acc      <= acc ^ fold_term(mem.mem_rdata);
                        tacc     <= tacc ^ fold_term(mem.mem_rdata);
                        cur_addr <= cur_addr + ADDR_W'(4);
                        remain   <= remain - CNT_W'(1);
                    end
                end
                S_WR_REV: begin
                    // Only a fully written result reaches the checksum output;
                    // aborted jobs leave the previous value in place.
                    if (mem.mem_gnt && !timed_out) begin
                        checksum_q <= acc;
                    end
                end
                default: begin
                end
            endcase
            if (timed_out) begin
                err_q <= 1'b1;
            end
        end
    end

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_FIN);
    assign error    = (state == S_FIN) && err_q;
    assign checksum = checksum_q;

endmodule
